// File: rtl/analog_channel_model_pkg.sv
// Shared types and voltage helpers for the LArPix-v2 analog channel model.
// Holds the SAR ADC state encoding and the threshold / trial-voltage arithmetic.
package analog_channel_model_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_CONVERT = 2'd2
  } adc_state_e;

  // Trim DAC step is a quarter of the global DAC step.
  function automatic real threshold_v(real voffset, int gbits, int glob, int trim);
    real glsb;
    glsb = voffset / real'(1 << gbits);
    return voffset - real'(glob) * glsb - real'(trim) * (glsb / 4.0);
  endfunction

  function automatic real trial_v(real vref, real vcm, int adcbits, int code);
    real lsb;
    lsb = 2.0 * (vref - vcm) / real'(1 << adcbits);
    return (2.0 * vcm - vref) + real'(code) * lsb;
  endfunction

endpackage

// File: rtl/analog_channel_model_if.sv
// Channel-side signal bundle: charge source / controller (master) to analog channel (slave).
// Optional DAC test pins exist only when ADC_DAC_TEST_EN is defined.
interface analog_channel_model_if #(
  parameter int ADCBITS             = 10,
  parameter int PIXEL_TRIM_DAC_BITS = 5,
  parameter int GLOBAL_DAC_BITS     = 8
);
  real                            charge_in_r;
  logic                           csa_reset;
  logic [GLOBAL_DAC_BITS-1:0]     threshold_global;
  logic [PIXEL_TRIM_DAC_BITS-1:0] pixel_trim_dac;
  logic                           sample;
  logic                           strobe;
  real                            csa_vout_r;
  logic                           hit;
  logic                           comp;
  logic [ADCBITS-1:0]             dout;
  logic                           done;
`ifdef ADC_DAC_TEST_EN
  logic                           dac_test;
  logic [ADCBITS-1:0]             dac_word;
`endif

  modport master (
    output charge_in_r, csa_reset, threshold_global, pixel_trim_dac, sample, strobe,
`ifdef ADC_DAC_TEST_EN
    output dac_test, dac_word,
`endif
    input  csa_vout_r, hit, comp, dout, done
  );

  modport slave (
    input  charge_in_r, csa_reset, threshold_global, pixel_trim_dac, sample, strobe,
`ifdef ADC_DAC_TEST_EN
    input  dac_test, dac_word,
`endif
    output csa_vout_r, hit, comp, dout, done
  );

endinterface

// File: rtl/analog_channel_model_afe_sar_adc.sv
// SAR ADC: tracks vin while sampling, then one binary-search decision per strobed edge.
// Optional ADC_DAC_TEST_EN lets comp follow a static DAC word outside of conversions.
module afe_sar_adc
  import analog_channel_model_pkg::*;
#(
  parameter real VREF    = 1.0,
  parameter real VCM     = 0.5,
  parameter int  ADCBITS = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  real                vin_i,
  input  logic               sample_i,
  input  logic               strobe_i,
`ifdef ADC_DAC_TEST_EN
  input  logic               dac_test_i,
  input  logic [ADCBITS-1:0] dac_word_i,
`endif
  output logic               comp_o,
  output logic [ADCBITS-1:0] dout_o,
  output logic               done_o
);

  localparam int IW = (ADCBITS > 1) ? $clog2(ADCBITS) : 1;

  adc_state_e         state_q;
  real                vhold_q;
  logic [IW-1:0]      idx_q;
  logic [ADCBITS-1:0] result_q;
  logic [ADCBITS-1:0] trial_d;
  logic               keep_d;
  logic               comp_q;
  logic [ADCBITS-1:0] dout_q;
  logic               done_q;

  always_comb begin
    trial_d = result_q | ({{(ADCBITS-1){1'b0}}, 1'b1} << idx_q);
    keep_d  = (vhold_q >= trial_v(VREF, VCM, ADCBITS, int'(trial_d)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      vhold_q  <= 0.0;
      idx_q    <= IW'(ADCBITS-1);
      result_q <= '0;
      comp_q   <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sample_i || state_q == ST_TRACK) vhold_q <= vin_i;
      // Sampling wins over everything, including an in-flight conversion.
      if (sample_i) begin
        state_q <= ST_TRACK;
      end else begin
        case (state_q)
          ST_TRACK: begin
            state_q  <= ST_CONVERT;
            idx_q    <= IW'(ADCBITS-1);
            result_q <= '0;
          end
          ST_CONVERT: begin
            if (strobe_i) begin
              comp_q <= keep_d;
              if (keep_d) result_q <= trial_d;
              if (idx_q == '0) begin
                dout_q  <= keep_d ? trial_d : result_q;
                done_q  <= 1'b1;
                state_q <= ST_IDLE;
              end else begin
                idx_q <= idx_q - 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
`ifdef ADC_DAC_TEST_EN
      if (dac_test_i && state_q != ST_CONVERT)
        comp_q <= (vhold_q >= trial_v(VREF, VCM, ADCBITS, int'(dac_word_i)));
`endif
    end
  end

  assign comp_o = comp_q;
  assign dout_o = dout_q;
  assign done_o = done_q;

endmodule

// File: rtl/analog_channel_model.sv
// LArPix-v2 pixel analog channel: CSA integrator, trimmed discriminator, SAR ADC.
// ADC_DAC_TEST_EN adds dac_test/dac_word pins that drive comp from a static DAC word.
module analog_channel_model
  import analog_channel_model_pkg::*;
#(
  parameter real VREF                = 1.0,
  parameter real VCM                 = 0.5,
  parameter int  ADCBITS             = 10,
  parameter int  PIXEL_TRIM_DAC_BITS = 5,
  parameter int  GLOBAL_DAC_BITS     = 8,
  parameter real CFB_CSA             = 40e-15,
  parameter real VOUT_DC_CSA         = 0.5,
  parameter real VDDA                = 1.8,
  parameter real VOFFSET             = 0.47
) (
  input logic                     clk,
  input logic                     reset,
  analog_channel_model_if.slave   ifc
);

  real  q_q;
  real  vraw;
  real  csa_vout;
  real  thr;
  logic hit_q;

  always_comb begin
    vraw = VOUT_DC_CSA - q_q / CFB_CSA;
    if (vraw < 0.0)       csa_vout = 0.0;
    else if (vraw > VDDA) csa_vout = VDDA;
    else                  csa_vout = vraw;
    thr = threshold_v(VOFFSET, GLOBAL_DAC_BITS,
                      int'(ifc.threshold_global), int'(ifc.pixel_trim_dac));
  end

  // A CSA reset edge drops the packet arriving on that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q   <= 0.0;
      hit_q <= 1'b0;
    end else begin
      q_q   <= ifc.csa_reset ? 0.0 : q_q + ifc.charge_in_r;
      hit_q <= (csa_vout < thr);
    end
  end

  assign ifc.csa_vout_r = csa_vout;
  assign ifc.hit        = hit_q;

  afe_sar_adc #(
    .VREF    (VREF),
    .VCM     (VCM),
    .ADCBITS (ADCBITS)
  ) u_adc (
    .clk        (clk),
    .reset      (reset),
    .vin_i      (csa_vout),
    .sample_i   (ifc.sample),
    .strobe_i   (ifc.strobe),
`ifdef ADC_DAC_TEST_EN
    .dac_test_i (ifc.dac_test),
    .dac_word_i (ifc.dac_word),
`endif
    .comp_o     (ifc.comp),
    .dout_o     (ifc.dout),
    .done_o     (ifc.done)
  );

endmodule

// File: tb/tb_analog_channel_model.sv
// Directed bench for analog_channel_model: CSA/discriminator vector table plus ADC sequences.
module tb_analog_channel_model;
  import analog_channel_model_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  analog_channel_model_if #(.ADCBITS(10), .PIXEL_TRIM_DAC_BITS(5), .GLOBAL_DAC_BITS(8)) ifc ();

  analog_channel_model dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    real        charge;
    logic       csa_rst;
    logic [7:0] glob;
    logic [4:0] trim;
    real        exp_vout;
    logic       exp_hit;
  } vec_t;

  vec_t vecs[12];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_code(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp);
    checks++;
    if (act > exp + 1e-9 || act < exp - 1e-9) begin
      errors++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  task automatic tk(inout int t, inout int ndone, inout int dtick);
    @(negedge clk);
    t++;
    if (ifc.done === 1'b1) begin
      ndone++;
      if (dtick < 0) dtick = t;
    end
  endtask

  // Sample 2 ticks, start tick, then 10 strobes separated by 'gap' idle ticks.
  // abort_after > 0 raises sample again after that many strobes.
  task automatic conv(input int gap, input int abort_after, output int ndone, output int dtick);
    int t;
    t = 0; ndone = 0; dtick = -1;
    ifc.strobe = 1'b0;
    ifc.sample = 1'b1;
    tk(t, ndone, dtick);
    tk(t, ndone, dtick);
    ifc.sample = 1'b0;
    tk(t, ndone, dtick);
    for (int k = 0; k < 10; k++) begin
      if (abort_after > 0 && k == abort_after) begin
        ifc.strobe = 1'b0;
        ifc.sample = 1'b1;
        tk(t, ndone, dtick);
        tk(t, ndone, dtick);
        ifc.sample = 1'b0;
        break;
      end
      ifc.strobe = 1'b1;
      tk(t, ndone, dtick);
      ifc.strobe = 1'b0;
      if (k != 9) repeat (gap) tk(t, ndone, dtick);
    end
    ifc.strobe = 1'b0;
    repeat (3) tk(t, ndone, dtick);
  endtask

  int nd;
  int dt;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{0.0,    1'b0, 8'd0,   5'd0,  0.5, 1'b0};
    vecs[1]  = '{4e-15,  1'b0, 8'd0,   5'd0,  0.4, 1'b0};
    vecs[2]  = '{0.0,    1'b0, 8'd0,   5'd0,  0.4, 1'b1};
    vecs[3]  = '{1e-15,  1'b1, 8'd0,   5'd0,  0.5, 1'b1};
    vecs[4]  = '{0.0,    1'b0, 8'd0,   5'd0,  0.5, 1'b0};
    vecs[5]  = '{4e-15,  1'b0, 8'd255, 5'd0,  0.4, 1'b0};
    vecs[6]  = '{0.0,    1'b0, 8'd255, 5'd0,  0.4, 1'b0};
    vecs[7]  = '{0.0,    1'b0, 8'd0,   5'd31, 0.4, 1'b1};
    vecs[8]  = '{0.0,    1'b0, 8'd200, 5'd0,  0.4, 1'b0};
    vecs[9]  = '{20e-15, 1'b0, 8'd0,   5'd0,  0.0, 1'b1};
    vecs[10] = '{0.0,    1'b1, 8'd0,   5'd0,  0.5, 1'b1};
    vecs[11] = '{0.0,    1'b0, 8'd0,   5'd0,  0.5, 1'b0};

    reset                = 1'b1;
    ifc.charge_in_r      = 0.0;
    ifc.csa_reset        = 1'b0;
    ifc.threshold_global = '0;
    ifc.pixel_trim_dac   = '0;
    ifc.sample           = 1'b0;
    ifc.strobe           = 1'b0;
`ifdef ADC_DAC_TEST_EN
    ifc.dac_test         = 1'b0;
    ifc.dac_word         = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_real("rst_vout", ifc.csa_vout_r, 0.5);
    check_bit("rst_hit", ifc.hit, 1'b0);
    check_code("rst_dout", ifc.dout, 10'd0);
    check_bit("rst_done", ifc.done, 1'b0);
    check_bit("rst_comp", ifc.comp, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ifc.charge_in_r      = vecs[i].charge;
      ifc.csa_reset        = vecs[i].csa_rst;
      ifc.threshold_global = vecs[i].glob;
      ifc.pixel_trim_dac   = vecs[i].trim;
      @(negedge clk);
      check_real($sformatf("vec%0d_vout", i), ifc.csa_vout_r, vecs[i].exp_vout);
      check_bit($sformatf("vec%0d_hit", i), ifc.hit, vecs[i].exp_hit);
    end
    ifc.charge_in_r      = 0.0;
    ifc.csa_reset        = 1'b0;
    ifc.threshold_global = '0;
    ifc.pixel_trim_dac   = '0;

    // Baseline 0.5 V -> midscale
    conv(0, 0, nd, dt);
    check_code("base_dout", ifc.dout, 10'd512);
    check_int("base_ndone", nd, 1);
    check_int("base_done_tick", dt, 13);
    check_bit("base_comp_lsb", ifc.comp, 1'b0);

    // Clamped to 0 V -> below VLOW gives code 0
    ifc.charge_in_r = 20e-15;
    @(negedge clk);
    ifc.charge_in_r = 0.0;
    check_real("clamp_vout", ifc.csa_vout_r, 0.0);
    conv(0, 0, nd, dt);
    check_code("zero_dout", ifc.dout, 10'd0);
    check_int("zero_ndone", nd, 1);

    ifc.csa_reset = 1'b1;
    @(negedge clk);
    ifc.csa_reset   = 1'b0;
    ifc.charge_in_r = 4e-15;
    @(negedge clk);
    ifc.charge_in_r = 0.0;
    check_real("v040_vout", ifc.csa_vout_r, 0.4);

    conv(0, 0, nd, dt);
    check_code("v040_dout", ifc.dout, 10'd409);
    check_int("v040_ndone", nd, 1);
    check_int("v040_done_tick", dt, 13);
    check_bit("v040_comp_lsb", ifc.comp, 1'b1);

    conv(2, 0, nd, dt);
    check_code("gap_dout", ifc.dout, 10'd409);
    check_int("gap_ndone", nd, 1);
    check_int("gap_done_tick", dt, 31);

    conv(0, 5, nd, dt);
    check_int("abort_ndone", nd, 0);
    check_code("abort_dout", ifc.dout, 10'd409);

    // Reset asserted partway through a conversion
    ifc.sample = 1'b1;
    repeat (2) @(negedge clk);
    ifc.sample = 1'b0;
    @(negedge clk);
    ifc.strobe = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("mid_comp_bit8", ifc.comp, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_code("midrst_dout", ifc.dout, 10'd0);
    check_bit("midrst_done", ifc.done, 1'b0);
    check_bit("midrst_comp", ifc.comp, 1'b0);
    check_bit("midrst_hit", ifc.hit, 1'b0);
    check_real("midrst_vout", ifc.csa_vout_r, 0.5);
    check_bit("midrst_idle", dut.u_adc.state_q == ST_IDLE, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) nd++;
    end
    ifc.strobe = 1'b0;
    check_int("post_rst_ndone", nd, 0);
    check_code("post_rst_dout", ifc.dout, 10'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
